// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: a generic pipeline stage register for the CPU datapath.
// It carries a data bundle and a control bundle under a valid/ready handshake
// and supports an explicit stall and a flush. A main register and a skid
// register together hold up to two entries, so in_ready comes from a flop and
// never from a combinational path through downstream logic.
// A bubble always presents all-zero control.
// Optional feature: define PIPE_PERF_CNT_EN to add saturating stall/flush
// performance counters.
`default_nettype none

module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q;
  entry_t in_ent;
  logic   take_in;
  logic   take_out;

  assign in_ent    = '{ctrl: in_ctrl, data: in_data};
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign take_in   = in_valid & in_ready_q;
  assign take_out  = out_valid & out_ready & ~stall;
  assign out_data  = main_q.data;
  // Belt and braces: main is already zero when empty, but gating here makes
  // the "bubble carries no control" guarantee independent of the datapath.
  assign out_ctrl  = out_valid ? main_q.ctrl : '0;

  // Next-state logic: flush empties the stage, otherwise move entries in FIFO order.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (take_in) begin
            state_d = ONE;
            main_d  = in_ent;
          end
        end
        ONE: begin
          if (take_in && !take_out) begin
            state_d = TWO;
            skid_d  = in_ent;
          end else if (take_in && take_out) begin
            main_d  = in_ent;
          end else if (take_out) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        TWO: begin
          // in_ready is low here, so only a departure can happen.
          if (take_out) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State, entry registers and registered in_ready; rst wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the entry registers are reset too, so out_data/out_ctrl read
      // as zero straight out of reset instead of carrying X garbage.
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [1:0]       n_held;
  logic [CNT_W:0]   flush_sum;

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Entries lost on a flush: everything held plus any offered input.
  always_comb begin
    n_held = 2'd0;
    if (state_q == ONE) n_held = 2'd1;
    if (state_q == TWO) n_held = 2'd2;
    flush_sum = {1'b0, flush_cnt_q} + (CNT_W+1)'(n_held) + (CNT_W+1)'(in_valid);
  end

  // Saturating performance counters, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !take_out && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush) begin
        flush_cnt_q <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_pipe_stage_skid;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  always #5 clk = ~clk;

`ifdef PIPE_PERF_CNT_EN
  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
`else
  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt (stall_cnt)
    , .flush_cnt (flush_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: a bounded FIFO of at most two entries.
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t              mq[$];
  longint unsigned   m_stall = 0;
  longint unsigned   m_flush = 0;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 1;

  typedef struct {
    logic              r, iv, st, fl, ordy;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic              e_ov, e_ir;
    logic [DATA_W-1:0] e_d;
    logic [CTRL_W-1:0] e_c;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [DATA_W-1:0] d, logic [CTRL_W-1:0] c,
                              logic st, logic fl, logic ordy, logic e_ov, logic e_ir,
                              logic [DATA_W-1:0] e_d, logic [CTRL_W-1:0] e_c);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.c = c; v.st = st; v.fl = fl; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_d = e_d; v.e_c = e_c;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (from a negedge), advance the model across the
  // rising edge, and return at the following negedge for sampling.
  task automatic apply(input logic r, input logic iv, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic st, input logic fl,
                       input logic ordy);
    bit m_out, m_in;
    rst = r; in_valid = iv; in_data = d; in_ctrl = c;
    stall = st; flush = fl; out_ready = ordy;
    @(posedge clk);
    m_out = (mq.size() > 0) && ordy && !st;
    m_in  = iv && (mq.size() < 2);
    if (r) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if ((mq.size() > 0) && !m_out) m_stall = (m_stall == CNT_MAX) ? CNT_MAX : m_stall + 1;
      if (fl) begin
        m_flush = m_flush + mq.size() + (iv ? 1 : 0);
        if (m_flush > CNT_MAX) m_flush = CNT_MAX;
        mq.delete();
      end else begin
        if (m_out) void'(mq.pop_front());
        if (m_in)  mq.push_back('{c: c, d: d});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    apply(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_valid"}, 128'(out_valid), 128'(mq.size() > 0));
    check({tag, ".in_ready"},  128'(in_ready),  128'(mq.size() < 2));
    check({tag, ".out_data"},  128'(out_data),  (mq.size() > 0) ? 128'(mq[0].d) : 128'(0));
    check({tag, ".out_ctrl"},  128'(out_ctrl),  (mq.size() > 0) ? 128'(mq[0].c) : 128'(0));
`ifdef PIPE_PERF_CNT_EN
    check({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(m_stall));
    check({tag, ".flush_cnt"}, 128'(flush_cnt), 128'(m_flush));
`endif
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;

    //          r  iv data   ctrl st fl or   ov ir e_data e_ctrl
    vecs.push_back(mk(1, 0, 0,     0,   0, 0, 0,   0, 1, 0,     0));   // reset
    vecs.push_back(mk(0, 0, 0,     0,   0, 0, 0,   0, 1, 0,     0));   // idle
    vecs.push_back(mk(0, 1, 'h11,  'h3, 0, 0, 1,   1, 1, 'h11,  'h3)); // 1-cycle latency
    vecs.push_back(mk(0, 0, 0,     0,   0, 0, 1,   0, 1, 0,     0));   // consumed
    vecs.push_back(mk(0, 1, 'hA,   'h1, 0, 0, 0,   1, 1, 'hA,   'h1)); // A held
    vecs.push_back(mk(0, 1, 'hB,   'h2, 0, 0, 0,   1, 0, 'hA,   'h1)); // B to skid: TWO
    vecs.push_back(mk(0, 1, 'hC,   'h9, 0, 0, 0,   1, 0, 'hA,   'h1)); // C refused
    vecs.push_back(mk(0, 0, 0,     0,   0, 0, 1,   1, 1, 'hB,   'h2)); // A leaves, B next
    vecs.push_back(mk(0, 0, 0,     0,   0, 0, 1,   0, 1, 0,     0));   // B leaves
    vecs.push_back(mk(0, 1, 'h21,  'h4, 0, 0, 0,   1, 1, 'h21,  'h4));
    vecs.push_back(mk(0, 1, 'h22,  'h8, 0, 0, 0,   1, 0, 'h21,  'h4)); // TWO
    vecs.push_back(mk(0, 1, 'h23,  'h5, 0, 1, 0,   0, 1, 0,     0));   // flush in TWO
    vecs.push_back(mk(0, 0, 0,     0,   0, 0, 1,   0, 1, 0,     0));   // dropped input absent
    vecs.push_back(mk(0, 1, 'h31,  'h6, 0, 0, 0,   1, 1, 'h31,  'h6));
    vecs.push_back(mk(0, 1, 'h32,  'h7, 0, 0, 0,   1, 0, 'h31,  'h6)); // TWO
    vecs.push_back(mk(1, 1, 'h33,  'h3, 0, 1, 0,   0, 1, 0,     0));   // rst+flush+in_valid
    vecs.push_back(mk(0, 1, 'h44,  'h5, 0, 0, 0,   1, 1, 'h44,  'h5)); // first push after rst
    vecs.push_back(mk(0, 0, 0,     0,   0, 0, 1,   0, 1, 0,     0));
    vecs.push_back(mk(0, 1, 'h51,  'h7, 0, 0, 0,   1, 1, 'h51,  'h7));
    vecs.push_back(mk(0, 1, 'h52,  'h1, 0, 1, 1,   0, 1, 0,     0));   // flush in ONE
    vecs.push_back(mk(0, 0, 0,     0,   0, 0, 1,   0, 1, 0,     0));

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].st, vecs[i].fl, vecs[i].ordy);
      check($sformatf("vec%0d.out_valid", i), 128'(out_valid), 128'(vecs[i].e_ov));
      check($sformatf("vec%0d.in_ready", i),  128'(in_ready),  128'(vecs[i].e_ir));
      check($sformatf("vec%0d.out_data", i),  128'(out_data),  128'(vecs[i].e_d));
      check($sformatf("vec%0d.out_ctrl", i),  128'(out_ctrl),  128'(vecs[i].e_c));
    end

    // Streaming: 1..8 back to back, each emerging the cycle after it enters.
    apply(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      apply(1'b0, 1'b1, DATA_W'(i), CTRL_W'(i), 1'b0, 1'b0, 1'b1);
      check($sformatf("stream%0d.out_valid", i), 128'(out_valid), 128'(1));
      check($sformatf("stream%0d.out_data", i),  128'(out_data),  128'(i));
      check($sformatf("stream%0d.in_ready", i),  128'(in_ready),  128'(1));
    end
    idle(1'b1);
    check("stream.drained", 128'(out_valid), 128'(0));

    // Stall: entry 0x5 held for three stalled cycles despite out_ready=1.
    apply(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 'h5, 'h2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      check($sformatf("stall%0d.out_valid", i), 128'(out_valid), 128'(1));
      check($sformatf("stall%0d.out_data", i),  128'(out_data),  128'(5));
    end
`ifdef PIPE_PERF_CNT_EN
    check("stall.stall_cnt", 128'(stall_cnt), 128'(3));
`endif
    idle(1'b1);
    check("stall.released", 128'(out_valid), 128'(0));

    // Flush in TWO with an offered input: three entries discarded.
    apply(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 'h61, 'h1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 'h62, 'h2, 1'b0, 1'b0, 1'b0);
    check("flush.pre_in_ready", 128'(in_ready), 128'(0));
    apply(1'b0, 1'b1, 'h63, 'h3, 1'b0, 1'b1, 1'b0);
    check("flush.out_valid", 128'(out_valid), 128'(0));
    check("flush.out_ctrl",  128'(out_ctrl),  128'(0));
    check("flush.in_ready",  128'(in_ready),  128'(1));
`ifdef PIPE_PERF_CNT_EN
    check("flush.flush_cnt", 128'(flush_cnt), 128'(3));
`endif

    // Randomized traffic against the FIFO model.
    apply(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic              r, iv, st, fl, ordy;
      logic [DATA_W-1:0] d;
      r    = ($urandom_range(0, 199) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      st   = ($urandom_range(0, 3) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      iv   = ($urandom_range(0, 3) != 0);
      d    = {$urandom, $urandom, $urandom};
      apply(r, iv, d, CTRL_W'($urandom), st, fl, ordy);
      check_model($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline stage register for the CPU datapath, replacing the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle with a valid/ready handshake, an explicit stall and a flush.
- A 2-entry skid buffer registers in_ready, so upstream never sees a combinational ready path from downstream.
- A bubble (valid=0) always presents all-zero control, so a flushed slot can never write the register file or memory.

Parameters:
DATA_W, 96, width of data bundle (e.g. PC+4, ALU result, store data)
CTRL_W, 16, width of control bundle (e.g. RegWrite, MemWrite, MemtoReg, Load/Store codes, dest addr)
CNT_W, 16, width of each performance counter (used only with PIPE_PERF_CNT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream presents an entry
in_ready  out  1  stage can accept; registered
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
stall  in  1  hazard-unit hold; blocks output transfer
flush  in  1  discard all held entries and the current input
out_valid  out  1  entry held in main register
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main register data
out_ctrl  out  CTRL_W  main register control; 0 when out_valid=0
stall_cnt  out  CNT_W  (PIPE_PERF_CNT_EN only) cycles with out_valid=1 and no output transfer
flush_cnt  out  CNT_W  (PIPE_PERF_CNT_EN only) entries discarded by flush

Behaviour:
- Transfer signals:
  - take_in = in_valid & in_ready.
  - take_out = out_valid & out_ready & ~stall.
- States:
  - EMPTY: no entry held.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Outputs per state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO), registered with the state.
- Reset (rst=1): state=EMPTY; main, skid, out_data and out_ctrl=0; in_ready=1; counters=0. rst overrides flush and every transfer.
- Flush (rst=0, flush=1):
  - Next state=EMPTY; main and skid cleared to 0; in_ready=1 next cycle.
  - Any input offered in that cycle is dropped, even if take_in=1.
  - out_valid may be 1 during the flush cycle. Downstream consuming it that cycle is legal, and the hazard unit is responsible for that.
- Transitions (rst=0, flush=0):
  - EMPTY, take_in → ONE; main<=in.
  - ONE, take_in & ~take_out → TWO; skid<=in.
  - ONE, take_in & take_out → ONE; main<=in.
  - ONE, ~take_in & take_out → EMPTY; main<=0.
  - TWO, take_out → ONE; main<=skid, skid<=0. No take_in is possible, since in_ready=0.
  - All other cases: hold.
- Stall: takes effect combinationally in the same cycle. While stall=1 the held entries freeze. The stage may still absorb one input into skid, which brings it to TWO.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush.
- Latency: 1 cycle from take_in to out_valid when starting from EMPTY. Throughput is 1 entry/cycle when out_ready=1 and stall=0.
- Data is never inspected; widths are passed through unchanged.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined:
  - stall_cnt increments each cycle with out_valid=1 and take_out=0.
  - flush_cnt adds the number of valid entries discarded on a flush: 0, 1 or 2, plus 1 if in_valid=1 in that cycle, so at most 3 per flush.
  - Both counters saturate at all-ones and clear only on rst.
- When undefined: the counter ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle → out_valid=0, out_ctrl=0, in_ready=1. Push data=0x11, ctrl=0x3 with out_ready=1 → out_valid=1 next cycle, out_data=0x11, out_ctrl=0x3.
- Streaming: in_valid=1 with out_ready=1 for 8 cycles, data 1..8 → output 1..8 on consecutive cycles, in_ready stays 1.
- Backpressure: out_ready=0, push A=0xA then B=0xB → state TWO, in_ready=0. Raise out_ready → A, then B; in_ready returns to 1 one cycle after A leaves.
- Stall: hold entry 0x5 with out_ready=1, stall=1 for 3 cycles → out_data stays 0x5 and is not consumed. With PIPE_PERF_CNT_EN, stall_cnt=3.
- Flush in TWO with in_valid=1 → next cycle out_valid=0, out_ctrl=0, in_ready=1; the dropped input never appears. With PIPE_PERF_CNT_EN, flush_cnt=3.
- rst asserted in TWO together with flush=1 and in_valid=1 → all outputs 0, in_ready=1, counters 0. The first push after reset emerges intact.
